coherence_bus_ctrl: RTL and testbench
=====================================

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

Interface
REQ-001 SHALL have parameter SNOOP_CYCLES, default 2: cycles the snooped cache is given to raise its write-back request.
REQ-002 SHALL have parameter ACCESS_CODE, default 2'b10: ramstate value that completes one word transfer.
REQ-003 SHALL have one clock and an asynchronous active-low reset. The clock is CLK (input, 1 bit). The reset is nRST (input, 1 bit).
REQ-004 SHALL provide the following per-cache ports, indexed by CPU 0/1:
- dREN  input  2: data read request.
- dWEN  input  2: data write request.
- daddr  input  2x32: word address.
- dstore  input  2x32: write data.
- cctrans  input  2: coherence transaction; miss fill in progress.
- ccwrite  input  2: fill is for a write, so other copies are invalidated.
REQ-005 SHALL provide the following per-cache outputs:
- dwait  output  2: active-high stall; low for one cycle per completed word.
- dload  output  2x32: read data, valid while dwait is low.
- ccwait  output  2: cache is held for snooping.
- ccinv  output  2: snooped cache must invalidate a hit.
- ccsnoopaddr  output  2x32: address being snooped.
REQ-006 SHALL provide the following RAM ports:
- ramREN  output  1: RAM read.
- ramWEN  output  1: RAM write.
- ramaddr  output  32: RAM address.
- ramstore  output  32: RAM write data.
- ramload  input  32: RAM read data.
- ramstate  input  2: RAM status.

Function
REQ-007 SHALL implement the FSM states IDLE, ARB, SNOOP, SNOOP_WB, FILL, WB, with exactly one bus master (the grantee g) at a time. The other cache is s = 1-g.
REQ-008 In IDLE, a request (dREN|dWEN) pending from either cache SHALL move the FSM to ARB. With no request, it SHALL stay in IDLE.
REQ-009 In ARB, the grant SHALL go round-robin: the CPU not granted last wins a tie, and a single requester always wins. After the grant, the FSM goes to SNOOP if cctrans[g], else to WB.
REQ-010 On entry to SNOOP:
- ccwait[s] SHALL be 1 and ccsnoopaddr[s] SHALL be daddr[g].
- ccinv[s] SHALL be ccwrite[g].
- These values SHALL be held until the transaction ends.
REQ-011 SNOOP SHALL last exactly SNOOP_CYCLES cycles. If dWEN[s] is seen in any of those cycles, the FSM goes to SNOOP_WB. Otherwise it goes to FILL.
REQ-012 In SNOOP_WB, the RAM port SHALL carry s's write: ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
- dwait[s] SHALL be low only in a cycle where ramstate==ACCESS_CODE.
- When dWEN[s] falls, the FSM goes to FILL.
REQ-013 In FILL: ramREN=1, ramaddr=daddr[g], dload[g]=ramload.
- dwait[g] SHALL be low exactly in the cycles where ramstate==ACCESS_CODE.
- When dREN[g] and cctrans[g] are both low, the transaction ends.
REQ-014 In WB, a plain write-back with no snoop: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
- dwait[g] low follows the same rule as REQ-013.
- When dWEN[g] falls, the transaction ends.
REQ-015 End of transaction:
- ccwait[s] and ccinv[s] SHALL return to 0.
- The last-granted record SHALL be set to g.
- The FSM SHALL return to IDLE.
REQ-016 dwait SHALL be 1 for every CPU that is not currently completing a word.
- ccwait[g] SHALL always be 0.
- ramREN and ramWEN SHALL never both be 1.
REQ-017 A request from g whose dREN and dWEN are both 1 SHALL be treated as a write (WB path).
REQ-018 A request from s arriving while g holds the bus SHALL wait, except s's write-back inside SNOOP/SNOOP_WB.
REQ-019 If the granted request drops in ARB before any word completes, the FSM SHALL return to IDLE with no RAM access and SHALL leave the last-granted record unchanged.
REQ-020 ramstate values other than ACCESS_CODE SHALL stall the FSM in its current state.

Reset
REQ-021 While nRST=0, the following SHALL hold:
- FSM in IDLE, last-granted = CPU 1 (so CPU 0 wins the first tie).
- dwait=2'b11, ccwait=0, ccinv=0.
- ccsnoopaddr=0, dload=0.
- ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-022 Reset asserted mid-transaction SHALL abort it immediately, with no further RAM access after nRST falls.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- CPU0 cctrans=1, dREN=1, ccwrite=0, daddr=0x100, with CPU1 silent → ccwait[1]=1 and ccsnoopaddr[1]=0x100 for 2 cycles, ccinv[1]=0, then FILL. RAM ACCESS returns 0xDEAD → dload[0]=0xDEAD with dwait[0]=0 for one cycle.
- CPU1 fill with ccwrite=1, daddr=0x200; CPU0 raises dWEN on snoop cycle 2 with dstore=0xBEEF → ccinv[0]=1, RAM written 0xBEEF at CPU0's daddr before the ramREN for 0x200.
- Both CPUs raise dWEN on the same cycle after reset → CPU0 served first, CPU1 next. A repeat tie → CPU0 again only if CPU1 was granted last.
- ramstate held at 2'b01 (busy) for 5 cycles during WB → dwait stays 1 and the FSM stays in WB. Then ACCESS → a single-cycle dwait low.
- nRST pulsed low during SNOOP_WB → all outputs at REQ-021 values in the same cycle. After release, the FSM is in IDLE.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - two-CPU snooping bus controller arbitrating one RAM port
// Round-robin grant, snoop window for the other cache, then fill or plain write-back.
module coherence_bus_ctrl #(
    parameter int         SNOOP_CYCLES = 2,
    parameter logic [1:0] ACCESS_CODE  = 2'b10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [63:0] daddr,
    input  logic [63:0] dstore,
    input  logic [1:0]  cctrans,
    input  logic [1:0]  ccwrite,
    output logic [1:0]  dwait,
    output logic [63:0] dload,
    output logic [1:0]  ccwait,
    output logic [1:0]  ccinv,
    output logic [63:0] ccsnoopaddr,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARB      = 3'd1;
    localparam logic [2:0] SNOOP    = 3'd2;
    localparam logic [2:0] SNOOP_WB = 3'd3;
    localparam logic [2:0] FILL     = 3'd4;
    localparam logic [2:0] WB       = 3'd5;

    localparam int CW = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SNOOP_LAST = CW'(SNOOP_CYCLES - 1);

    logic [2:0]    state;
    logic [2:0]    next;
    logic          g;
    logic          s;
    logic          last;
    logic          gsel;
    logic          seen;
    logic          access;
    logic [CW-1:0] cnt;
    logic [1:0]    req;
    logic [31:0]   addr_g;
    logic [31:0]   addr_s;
    logic [31:0]   store_g;
    logic [31:0]   store_s;
    logic          ending;

    assign s       = ~g;
    assign req     = dREN | dWEN;
    assign access  = (ramstate == ACCESS_CODE);
    assign addr_g  = g ? daddr[63:32]  : daddr[31:0];
    assign addr_s  = g ? daddr[31:0]   : daddr[63:32];
    assign store_g = g ? dstore[63:32] : dstore[31:0];
    assign store_s = g ? dstore[31:0]  : dstore[63:32];
    assign ending  = ((state == FILL) || (state == WB)) && (next == IDLE);

    // Tie goes to the CPU that was not granted last.
    always_comb begin
        gsel = 1'b0;
        if (req == 2'b11)
            gsel = ~last;
        else
            gsel = req[1];
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (|req)
                    next = ARB;
            end
            ARB: begin
                if (!(|req))
                    next = IDLE;
                else if (cctrans[gsel] && !(dREN[gsel] && dWEN[gsel]))
                    next = SNOOP;
                else
                    next = WB;
            end
            SNOOP: begin
                if (cnt == SNOOP_LAST)
                    next = (seen || dWEN[s]) ? SNOOP_WB : FILL;
            end
            SNOOP_WB: begin
                if (!dWEN[s])
                    next = FILL;
            end
            FILL: begin
                if (!dREN[g] && !cctrans[g])
                    next = IDLE;
            end
            WB: begin
                if (!dWEN[g])
                    next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            g           <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            seen        <= 1'b0;
            ccwait      <= 2'b00;
            ccinv       <= 2'b00;
            ccsnoopaddr <= 64'd0;
        end else begin
            state <= next;
            if ((state == ARB) && (|req)) begin
                g    <= gsel;
                cnt  <= '0;
                seen <= 1'b0;
                if (next == SNOOP) begin
                    ccwait      <= gsel ? 2'b01 : 2'b10;
                    ccinv       <= ccwrite[gsel] ? (gsel ? 2'b01 : 2'b10) : 2'b00;
                    ccsnoopaddr <= gsel ? {32'd0, daddr[63:32]} : {daddr[31:0], 32'd0};
                end
            end
            if (state == SNOOP) begin
                cnt <= cnt + 1'b1;
                if (dWEN[s])
                    seen <= 1'b1;
            end
            if (ending) begin
                last        <= g;
                ccwait      <= 2'b00;
                ccinv       <= 2'b00;
                ccsnoopaddr <= 64'd0;
            end
        end
    end

    // RAM strobes are dropped as soon as the owning request falls so the closing cycle is idle.
    always_comb begin
        dwait    = 2'b11;
        dload    = 64'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        case (state)
            SNOOP_WB: begin
                if (dWEN[s]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = addr_s;
                    ramstore = store_s;
                    if (access)
                        dwait = s ? 2'b01 : 2'b10;
                end
            end
            FILL: begin
                if (dREN[g] || cctrans[g]) begin
                    ramREN  = 1'b1;
                    ramaddr = addr_g;
                    dload   = g ? {ramload, 32'd0} : {32'd0, ramload};
                    if (access)
                        dwait = g ? 2'b01 : 2'b10;
                end
            end
            WB: begin
                if (dWEN[g]) begin
                    ramWEN   = 1'b1;
                    ramaddr  = addr_g;
                    ramstore = store_g;
                    if (access)
                        dwait = g ? 2'b01 : 2'b10;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - directed self-checking bench for coherence_bus_ctrl
module tb_coherence_bus_ctrl;

    localparam logic [1:0] ACC  = 2'b10;
    localparam logic [1:0] BUSY = 2'b01;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [1:0]  dREN = 2'b00;
    logic [1:0]  dWEN = 2'b00;
    logic [63:0] daddr = 64'd0;
    logic [63:0] dstore = 64'd0;
    logic [1:0]  cctrans = 2'b00;
    logic [1:0]  ccwrite = 2'b00;
    logic [1:0]  dwait;
    logic [63:0] dload;
    logic [1:0]  ccwait;
    logic [1:0]  ccinv;
    logic [63:0] ccsnoopaddr;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = 32'd0;
    logic [1:0]  ramstate = 2'b00;

    int n_tests = 0;
    int n_fail  = 0;

    coherence_bus_ctrl #(.SNOOP_CYCLES(2), .ACCESS_CODE(2'b10)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dwait"}, 64'(dwait), 64'd3);
        check({tag, "_ccwait_ccinv"}, 64'({ccwait, ccinv}), 64'd0);
        check({tag, "_snoopaddr"}, ccsnoopaddr, 64'd0);
        check({tag, "_dload"}, dload, 64'd0);
        check({tag, "_ramren_ramwen"}, 64'({ramREN, ramWEN}), 64'd0);
        check({tag, "_ramaddr_store"}, {ramaddr, ramstore}, 64'd0);
    endtask

    task automatic wait_wen(input string tag);
        int n = 0;
        while (!ramWEN && n < 8) begin
            step();
            n++;
        end
        if (!ramWEN)
            check({tag, "_timeout"}, 64'(ramWEN), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_idle("reset");
        step();
        step();
        nRST = 1'b1;
        step();

        // CPU0 read fill, CPU1 silent
        daddr   = {32'h0, 32'h100};
        cctrans = 2'b01;
        dREN    = 2'b01;
        step();
        step();
        check("s1_ccwait_c1", 64'(ccwait), 64'd2);
        check("s1_snoopaddr_c1", 64'(ccsnoopaddr[63:32]), 64'h100);
        check("s1_ccinv", 64'(ccinv), 64'd0);
        check("s1_noram_snoop", 64'({ramREN, ramWEN}), 64'd0);
        step();
        check("s1_ccwait_c2", 64'(ccwait), 64'd2);
        check("s1_snoopaddr_c2", 64'(ccsnoopaddr[63:32]), 64'h100);
        step();
        check("s1_fill_ren", 64'({ramREN, ramWEN}), 64'd2);
        check("s1_fill_addr", 64'(ramaddr), 64'h100);
        ramstate = ACC;
        ramload  = 32'hDEAD;
        #1;
        check("s1_dwait_low", 64'(dwait), 64'd2);
        check("s1_dload", 64'(dload[31:0]), 64'hDEAD);
        step();
        dREN     = 2'b00;
        cctrans  = 2'b00;
        ramstate = 2'b00;
        #1;
        check("s1_dwait_one_cycle", 64'(dwait), 64'd3);
        step();
        check_idle("s1_end");

        // CPU1 write fill, CPU0 writes back during snoop cycle 2
        daddr   = {32'h200, 32'h300};
        cctrans = 2'b10;
        dREN    = 2'b10;
        ccwrite = 2'b10;
        step();
        step();
        check("s2_ccwait", 64'(ccwait), 64'd1);
        check("s2_ccinv", 64'(ccinv), 64'd1);
        check("s2_snoopaddr", 64'(ccsnoopaddr[31:0]), 64'h200);
        step();
        dWEN   = 2'b01;
        dstore = {32'h0, 32'hBEEF};
        #1;
        step();
        check("s2_wb_wen", 64'({ramREN, ramWEN}), 64'd1);
        check("s2_wb_addr_store", {ramaddr, ramstore}, {32'h300, 32'hBEEF});
        ramstate = ACC;
        #1;
        check("s2_wb_dwait", 64'(dwait), 64'd2);
        step();
        dWEN     = 2'b00;
        ramstate = 2'b00;
        step();
        check("s2_fill_ren", 64'({ramREN, ramWEN}), 64'd2);
        check("s2_fill_addr", 64'(ramaddr), 64'h200);
        check("s2_ccinv_held", 64'(ccinv), 64'd1);
        ramstate = ACC;
        ramload  = 32'h1234;
        #1;
        check("s2_fill_dwait", 64'(dwait), 64'd1);
        check("s2_fill_dload", 64'(dload[63:32]), 64'h1234);
        step();
        dREN     = 2'b00;
        cctrans  = 2'b00;
        ccwrite  = 2'b00;
        ramstate = 2'b00;
        step();
        check_idle("s2_end");

        // plain write-back stalled by a busy RAM
        daddr  = {32'h0, 32'h40};
        dstore = {32'h0, 32'h55};
        dWEN   = 2'b01;
        step();
        step();
        ramstate = BUSY;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("s4_busy_dwait_%0d", i), 64'(dwait), 64'd3);
            check($sformatf("s4_busy_wb_%0d", i), {31'd0, ramWEN, ramaddr}, {31'd0, 1'b1, 32'h40});
            step();
        end
        ramstate = ACC;
        #1;
        check("s4_access_dwait", 64'(dwait), 64'd2);
        check("s4_store", 64'(ramstore), 64'h55);
        step();
        dWEN     = 2'b00;
        ramstate = 2'b00;
        #1;
        check("s4_dwait_single", 64'(dwait), 64'd3);
        step();
        check_idle("s4_end");

        // reset pulsed in SNOOP_WB
        daddr   = {32'h200, 32'h300};
        dstore  = {32'h0, 32'h77};
        cctrans = 2'b10;
        dREN    = 2'b10;
        ccwrite = 2'b10;
        step();
        step();
        dWEN     = 2'b01;
        ramstate = BUSY;
        step();
        step();
        check("s5_in_snoop_wb", 64'({ramREN, ramWEN}), 64'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_idle("s5_abort");
        dWEN     = 2'b00;
        dREN     = 2'b00;
        cctrans  = 2'b00;
        ccwrite  = 2'b00;
        ramstate = 2'b00;
        step();
        check_idle("s5_held");
        nRST = 1'b1;
        step();
        check_idle("s5_release");

        // tie after reset: CPU0 first, then CPU1
        daddr  = {32'h20, 32'h10};
        dstore = {32'hA1, 32'hA0};
        dWEN   = 2'b11;
        step();
        check("s3_arb_noram", 64'({ramREN, ramWEN}), 64'd0);
        step();
        check("s3_t1_wen", 64'(ramWEN), 64'd1);
        check("s3_t1_cpu0", {ramaddr, ramstore}, {32'h10, 32'hA0});
        ramstate = ACC;
        #1;
        check("s3_t1_dwait", 64'(dwait), 64'd2);
        step();
        dWEN     = 2'b10;
        ramstate = 2'b00;
        step();
        wait_wen("s3_t2");
        check("s3_t2_cpu1", {ramaddr, ramstore}, {32'h20, 32'hA1});
        ramstate = ACC;
        #1;
        check("s3_t2_dwait", 64'(dwait), 64'd1);
        step();
        dWEN     = 2'b00;
        ramstate = 2'b00;
        step();
        // repeat tie with CPU1 granted last
        dWEN = 2'b11;
        step();
        step();
        check("s3_t3_cpu0", {ramaddr, ramstore}, {32'h10, 32'hA0});
        ramstate = ACC;
        #1;
        step();
        dWEN     = 2'b10;
        ramstate = 2'b00;
        step();
        // tie with CPU0 granted last goes to CPU1
        dWEN = 2'b11;
        step();
        step();
        check("s3_t4_cpu1", {ramaddr, ramstore}, {32'h20, 32'hA1});
        ramstate = ACC;
        #1;
        check("s3_t4_dwait", 64'(dwait), 64'd1);
        step();
        dWEN     = 2'b01;
        ramstate = 2'b00;
        step();
        wait_wen("s3_t5");
        check("s3_t5_cpu0", {ramaddr, ramstore}, {32'h10, 32'hA0});
        ramstate = ACC;
        #1;
        step();
        dWEN     = 2'b00;
        ramstate = 2'b00;
        step();
        check_idle("s3_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
